// File: rtl/cnn_proto_pkg.sv
`default_nettype none
// ============================================================================
//  cnn_proto_pkg
//  Shared host-link protocol constants and types for the MNIST inference core:
//  command bytes, response markers, frame lengths and framer state encoding.
//  Revision: 1.0
// ============================================================================
package cnn_proto_pkg;

   // Response (device -> host) framing markers
   localparam logic [7:0] RESP_START1      = 8'hDD;
   localparam logic [7:0] RESP_START2      = 8'h77;
   localparam logic [7:0] RESP_END1        = 8'h77;
   localparam logic [7:0] RESP_END2        = 8'hDD;
   localparam logic [7:0] RESP_NACK        = 8'hEE;
   localparam logic [7:0] RESP_TYPE_DIGIT  = 8'h01;
   localparam logic [7:0] RESP_TYPE_SCORES = 8'h02;

   // Host request command bytes, as decoded by the receive router
   localparam logic [7:0] CMD_DIGIT        = 8'hCC;
   localparam logic [7:0] CMD_SCORES       = 8'hCD;

   localparam int NUM_CLASSES = 10;
   localparam int SCORE_W     = 32;
   localparam int SCORES_W    = NUM_CLASSES * SCORE_W;

   // Frame lengths in bytes
   localparam logic [5:0] LEN_DIGIT  = 6'd6;
   localparam logic [5:0] LEN_SCORES = 6'd45;
   localparam logic [5:0] LEN_NACK   = 6'd1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_SEND = 3'd2,
      ST_WAIT = 3'd3,
      ST_DONE = 3'd4
   } tx_state_t;

   typedef enum logic [1:0] {
      FR_NACK   = 2'd0,
      FR_DIGIT  = 2'd1,
      FR_SCORES = 2'd2
   } frame_kind_t;

   // Payload byte of a score frame. Scores are packed little-endian with
   // score 0 first, so payload byte j is simply byte j of the score vector.
   function automatic logic [7:0] score_byte(input logic [SCORES_W-1:0] scores,
                                             input logic [5:0]          idx);
      logic [5:0]          j;
      logic [8:0]          bit_off;
      logic [SCORES_W-1:0] shifted;
      j       = idx - 6'd3;
      bit_off = {j, 3'b000};
      shifted = scores >> bit_off;
      return shifted[7:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  uart_tx
//  8N1 bit serializer. Accepts a byte on start while idle, shifts out start
//  bit, 8 data bits LSB first and a stop bit, BIT_CYCLES clocks per bit.
//  done pulses during the last cycle of the stop bit.
//  Revision: 1.0
// ============================================================================
module uart_tx #(
   parameter int BIT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       start,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int             CW        = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 2;
   localparam logic [CW-1:0]  BAUD_LAST = CW'(BIT_CYCLES - 1);

   logic [CW-1:0] baud_cnt;
   logic [3:0]    bit_cnt;
   logic [8:0]    shreg;     // remaining data bits with the stop bit on top

   // Done is asserted in the final stop-bit cycle so the framer can issue the
   // next byte with a single idle clock in between.
   assign done = busy && (bit_cnt == 4'd9) && (baud_cnt == BAUD_LAST);

   // Bit timing and shift register
   always_ff @(posedge clk) begin
      if (rst) begin
         tx       <= 1'b1;
         busy     <= 1'b0;
         baud_cnt <= '0;
         bit_cnt  <= 4'd0;
         shreg    <= 9'h1FF;
      end else if (!busy) begin
         if (start) begin
            tx       <= 1'b0;
            busy     <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= 4'd0;
            shreg    <= {1'b1, data};
         end
      end else if (baud_cnt == BAUD_LAST) begin
         baud_cnt <= '0;
         if (bit_cnt == 4'd9) begin
            busy <= 1'b0;
            tx   <= 1'b1;
         end else begin
            tx      <= shreg[0];
            shreg   <= {1'b1, shreg[8:1]};
            bit_cnt <= bit_cnt + 4'd1;
         end
      end else begin
         baud_cnt <= baud_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_result_tx.sv
`default_nettype none
// ============================================================================
//  uart_result_tx
//  Returns the latched classifier result (digit or ten scores) to the host as
//  a marker-framed byte stream on tx, in response to 0xCC / 0xCD commands.
//  Revision: 1.0
// ============================================================================
module uart_result_tx
   import cnn_proto_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 115200
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                result_valid,
   input  logic [3:0]          result_digit,
   input  logic [SCORES_W-1:0] result_scores,
   input  logic [7:0]          cmd_data,
   input  logic                cmd_valid,
   output logic                tx,
   output logic                busy,
   output logic                frame_done
);

   localparam int BIT_CYCLES = CLK_FREQ / BAUD;

   logic [3:0]          hold_digit;
   logic [SCORES_W-1:0] hold_scores;
   logic                have_result;

   logic [3:0]          snap_digit;
   logic [SCORES_W-1:0] snap_scores;
   frame_kind_t         kind;
   tx_state_t           state;
   logic [5:0]          byte_idx;
   logic [5:0]          frame_len;

   logic [7:0]          byte_out;
   logic                ser_start;
   logic                ser_busy;
   logic                ser_done;
   logic                cmd_known;

   assign cmd_known = (cmd_data == CMD_DIGIT) || (cmd_data == CMD_SCORES);
   assign ser_start = (state == ST_SEND) && !ser_busy;

   // Result holding registers; may update at any time, frames use a snapshot
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_digit  <= 4'd0;
         hold_scores <= '0;
         have_result <= 1'b0;
      end else if (result_valid) begin
         hold_digit  <= result_digit;
         hold_scores <= result_scores;
         have_result <= 1'b1;
      end
   end

   // Framer: command accept, snapshot, byte sequencing and status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         kind        <= FR_NACK;
         snap_digit  <= 4'd0;
         snap_scores <= '0;
         byte_idx    <= 6'd0;
         frame_len   <= 6'd0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid && cmd_known) begin
                  busy  <= 1'b1;
                  state <= ST_LOAD;
                  // A result arriving in the same cycle counts as present
                  if (!(have_result || result_valid))
                     kind <= FR_NACK;
                  else if (cmd_data == CMD_DIGIT)
                     kind <= FR_DIGIT;
                  else
                     kind <= FR_SCORES;
               end
            end
            ST_LOAD: begin
               snap_digit  <= hold_digit;
               snap_scores <= hold_scores;
               byte_idx    <= 6'd0;
               case (kind)
                  FR_DIGIT:  frame_len <= LEN_DIGIT;
                  FR_SCORES: frame_len <= LEN_SCORES;
                  default:   frame_len <= LEN_NACK;
               endcase
               state <= ST_SEND;
            end
            ST_SEND: begin
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (ser_done) begin
                  if (byte_idx == frame_len - 6'd1) begin
                     state      <= ST_DONE;
                     busy       <= 1'b0;
                     frame_done <= 1'b1;
                  end else begin
                     byte_idx <= byte_idx + 6'd1;
                     state    <= ST_SEND;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Byte mux: select the frame byte at byte_idx from the snapshot
   always_comb begin
      byte_out = RESP_NACK;
      case (kind)
         FR_DIGIT: begin
            case (byte_idx)
               6'd0:    byte_out = RESP_START1;
               6'd1:    byte_out = RESP_START2;
               6'd2:    byte_out = RESP_TYPE_DIGIT;
               6'd3:    byte_out = {4'h0, snap_digit};
               6'd4:    byte_out = RESP_END1;
               default: byte_out = RESP_END2;
            endcase
         end
         FR_SCORES: begin
            case (byte_idx)
               6'd0:    byte_out = RESP_START1;
               6'd1:    byte_out = RESP_START2;
               6'd2:    byte_out = RESP_TYPE_SCORES;
               6'd43:   byte_out = RESP_END1;
               6'd44:   byte_out = RESP_END2;
               default: byte_out = score_byte(snap_scores, byte_idx);
            endcase
         end
         default: byte_out = RESP_NACK;
      endcase
   end

   uart_tx #(
      .BIT_CYCLES(BIT_CYCLES)
   ) u_uart_tx (
      .clk   (clk),
      .rst   (rst),
      .data  (byte_out),
      .start (ser_start),
      .tx    (tx),
      .busy  (ser_busy),
      .done  (ser_done)
   );

endmodule
`default_nettype wire

// File: tb/tb_uart_result_tx.sv
`default_nettype none
// ============================================================================
//  tb_uart_result_tx
//  Directed bench for uart_result_tx with a UART line monitor and an
//  expected-byte scoreboard.
//  Revision: 1.0
// ============================================================================
module tb_uart_result_tx;

   localparam int BC = 16;   // CLK_FREQ=16, BAUD=1

   logic         clk;
   logic         rst;
   logic         result_valid;
   logic [3:0]   result_digit;
   logic [319:0] result_scores;
   logic [7:0]   cmd_data;
   logic         cmd_valid;
   logic         tx;
   logic         busy;
   logic         frame_done;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int done_cnt  = 0;
   int cyc       = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rx_log[$];

   uart_result_tx #(
      .CLK_FREQ(16),
      .BAUD    (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .result_valid (result_valid),
      .result_digit (result_digit),
      .result_scores(result_scores),
      .cmd_data     (cmd_data),
      .cmd_valid    (cmd_valid),
      .tx           (tx),
      .busy         (busy),
      .frame_done   (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   // UART line monitor: decodes bytes and compares them with the scoreboard
   int         mon_cnt = 0;
   bit         mon_act = 0;
   logic [7:0] mon_byte;
   always @(negedge clk) begin
      if (frame_done === 1'b1) begin
         done_cnt++;
         check("busy_low_at_frame_done", busy, 1'b0);
      end
      if (rst) begin
         mon_act = 0;
      end else if (!mon_act) begin
         if (tx === 1'b0) begin
            mon_act = 1;
            mon_cnt = 0;
         end
      end else begin
         mon_cnt++;
         if (mon_cnt == BC/2) begin
            if (tx !== 1'b0) mon_act = 0;
         end else if (mon_cnt > BC/2 && ((mon_cnt - BC/2) % BC) == 0) begin
            int k;
            k = (mon_cnt - BC/2) / BC;
            if (k <= 8) begin
               mon_byte[k-1] = tx;
            end else begin
               check("rx_stop_bit", tx, 1'b1);
               rx_log.push_back(mon_byte);
               check("rx_byte_expected", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) check("rx_byte", mon_byte, exp_q.pop_front());
               mon_act = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_cmd(input logic [7:0] b);
      cmd_data  = b;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic set_result(input logic [3:0] d, input logic [319:0] s);
      result_digit  = d;
      result_scores = s;
      result_valid  = 1'b1;
      tick();
      result_valid  = 1'b0;
   endtask

   task automatic push_digit(input logic [3:0] d);
      exp_q.push_back(8'hDD); exp_q.push_back(8'h77); exp_q.push_back(8'h01);
      exp_q.push_back({4'h0, d});
      exp_q.push_back(8'h77); exp_q.push_back(8'hDD);
   endtask

   task automatic push_scores(input logic [319:0] s);
      exp_q.push_back(8'hDD); exp_q.push_back(8'h77); exp_q.push_back(8'h02);
      for (int k = 0; k < 10; k++)
         for (int b = 0; b < 4; b++)
            exp_q.push_back(s[k*32 + b*8 +: 8]);
      exp_q.push_back(8'h77); exp_q.push_back(8'hDD);
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (frame_done !== 1'b1 && n < 9000) begin
         tick();
         n++;
      end
      check(tag, frame_done, 1'b1);
   endtask

   task automatic wait_rx(input int count, input string tag);
      int n;
      n = 0;
      while (rx_log.size() < count && n < 9000) begin
         tick();
         n++;
      end
      check(tag, rx_log.size() >= count, 1'b1);
   endtask

   logic [319:0] scores_a, scores_b;
   int           k_lat, start_cyc, len, d0;
   bit           bad;

   initial begin
      for (int k = 0; k < 10; k++) begin
         scores_a[k*32 +: 32] = 32'h1000_0000 + k;
         scores_b[k*32 +: 32] = 32'hA5A5_0000 + (k * 32'h0101);
      end
      scores_a[9*32 +: 32] = 32'hFFFF_FFF6;

      rst = 1'b1; result_valid = 1'b0; result_digit = 4'd0; result_scores = '0;
      cmd_data = 8'h00; cmd_valid = 1'b0;
      repeat (4) tick();
      check("reset_tx", tx, 1'b1);
      check("reset_busy", busy, 1'b0);
      check("reset_frame_done", frame_done, 1'b0);
      rst = 1'b0;
      tick();

      // Unknown command byte is ignored
      pulse_cmd(8'h41);
      bad = 0;
      repeat (40) begin
         if (tx !== 1'b1 || busy !== 1'b0) bad = 1;
         tick();
      end
      check("ignored_cmd_quiet", bad, 1'b0);

      // Request before any result -> single NACK byte
      exp_q.push_back(8'hEE);
      rx_log.delete();
      pulse_cmd(8'hCD);
      wait_done("nack_frame_done");
      repeat (20) tick();
      check("nack_byte_count", rx_log.size(), 1);
      check("nack_scoreboard_empty", exp_q.size(), 0);

      // Digit frame, acceptance timing and frame length
      set_result(4'd7, scores_a);
      push_digit(4'd7);
      d0 = done_cnt;
      pulse_cmd(8'hCC);
      check("busy_after_accept", busy, 1'b1);
      k_lat = 1;
      while (tx !== 1'b0 && k_lat < 6) begin
         tick();
         k_lat++;
      end
      check("start_bit_latency", (k_lat >= 2 && k_lat <= 3), 1'b1);
      start_cyc = cyc;
      wait_done("digit_frame_done");
      len = cyc - start_cyc;
      check("digit_frame_length", (len >= 6*(10*BC+1)-1 && len <= 6*(10*BC+1)+1), 1'b1);

      // Command in the frame_done cycle is dropped, next cycle is accepted
      cmd_data  = 8'hCC;
      cmd_valid = 1'b1;
      tick();
      check("cmd_at_done_dropped", busy, 1'b0);
      check("digit_done_once", done_cnt - d0, 1);
      push_digit(4'd7);
      tick();
      cmd_valid = 1'b0;
      check("cmd_after_done_accepted", busy, 1'b1);
      wait_done("digit_frame2_done");
      tick();
      check("busy_low_after_digit", busy, 1'b0);

      // Score frame with a dropped command and a result update mid-frame
      push_scores(scores_a);
      rx_log.delete();
      pulse_cmd(8'hCD);
      wait_rx(5, "score_progress");
      pulse_cmd(8'hCC);
      set_result(4'd5, scores_b);
      wait_done("score_frame_done");
      repeat (20) tick();
      check("score_len", rx_log.size(), 45);
      if (rx_log.size() == 45) begin
         check("score_byte3", rx_log[3], 8'h00);
         check("score_byte6", rx_log[6], 8'h10);
         check("score_last0", rx_log[39], 8'hF6);
         check("score_last3", rx_log[42], 8'hFF);
         check("score_end1", rx_log[43], 8'h77);
         check("score_end2", rx_log[44], 8'hDD);
      end
      repeat (400) tick();
      check("no_second_frame", rx_log.size(), 45);
      check("score_scoreboard_empty", exp_q.size(), 0);

      push_digit(4'd5);
      pulse_cmd(8'hCC);
      wait_done("new_digit_frame_done");

      // Result and command in the same IDLE cycle -> new result is sent
      repeat (3) tick();
      push_digit(4'd9);
      result_digit = 4'd9; result_valid = 1'b1;
      cmd_data = 8'hCC;    cmd_valid = 1'b1;
      tick();
      result_valid = 1'b0; cmd_valid = 1'b0;
      wait_done("simul_frame_done");
      repeat (20) tick();
      check("simul_scoreboard_empty", exp_q.size(), 0);

      // Reset in the middle of byte 10 of a score frame
      push_scores(scores_b);
      rx_log.delete();
      pulse_cmd(8'hCD);
      wait_rx(10, "reach_byte10");
      repeat (20) tick();
      rst = 1'b1;
      tick();
      check("midreset_tx", tx, 1'b1);
      check("midreset_busy", busy, 1'b0);
      rst = 1'b0;
      exp_q.delete();
      repeat (400) tick();
      check("midreset_silent", rx_log.size(), 10);
      exp_q.push_back(8'hEE);
      pulse_cmd(8'hCD);
      wait_done("post_reset_nack_done");
      repeat (400) tick();
      check("final_scoreboard_empty", exp_q.size(), 0);
      check("post_reset_byte_count", rx_log.size(), 11);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_result_tx.md
# uart_result_tx

Transmit-side UART framer for the MNIST inference core. It latches the classifier result (predicted digit plus ten 32-bit dense-layer scores) and returns it to the host over `tx` when the host asks. Requests arrive as the `0xCC` / `0xCD` command bytes already decoded by the receive router. It is the return path of the same host link and uses the same marker-framed byte protocol in the opposite direction.

## Interface
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `BAUD`, 115200: line rate. `BIT_CYCLES = CLK_FREQ/BAUD` (integer divide, ≥ 4).
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `result_valid`  in  1  one-cycle pulse; latch `result_digit` / `result_scores`.
- `result_digit`  in  4  predicted class, 0–9.
- `result_scores`  in  320  ten signed 32-bit scores; score k is bits `[32k+31:32k]`.
- `cmd_data`  in  8  host command byte.
- `cmd_valid`  in  1  one-cycle pulse qualifying `cmd_data`.
- `tx`  out  1  UART serial out, 8N1, idle high.
- `busy`  out  1  high from the cycle a command is accepted until the last stop bit ends.
- `frame_done`  out  1  one-cycle pulse when the last stop bit ends.

## Operation
- **Result latch:** `result_valid` copies digit and scores into holding registers and sets `have_result`. This is allowed at any time, including mid-frame. A frame in flight never changes, because it reads a snapshot taken at frame start.
- **Command decode (IDLE only):**
  - `0xCC`: digit frame, 6 bytes: `DD 77 01 <digit zero-extended> 77 DD`.
  - `0xCD`: score frame, 45 bytes: `DD 77 02 <score0 byte0..byte3, …, score9 byte3> 77 DD`. Each score is sent little-endian, score 0 first.
  - `0xCC` or `0xCD` with `have_result=0`: single byte `EE`. No markers.
  - Any other byte: ignored. No output, `busy` stays low.
  - `cmd_valid` while `busy=1`: dropped silently. No queueing.
- **State machine:**
  - IDLE → LOAD on an accepted command.
  - LOAD: snapshot the holding registers into the frame shadow, set `byte_idx=0`, set `frame_len` to 6, 45 or 1; → SEND.
  - SEND: present byte `byte_idx` to the serializer with a one-cycle start; → WAIT.
  - WAIT, when the serializer finishes:
    - if `byte_idx == frame_len-1` → DONE;
    - else `byte_idx+1` and → SEND.
  - DONE: pulse `frame_done` → IDLE.
- **Byte select:**
  - digit frame: byte index selects directly.
  - score frame: for index i in 3..42, `score[(i-3)>>2]` byte `(i-3)&3`.
- `byte_idx` is 6 bits and never wraps past `frame_len-1`.

## Timing
- **Reset values:** `tx=1`, `busy=0`, `frame_done=0`, `have_result=0`, state IDLE, `byte_idx=0`, holding registers 0.
- **Reset mid-frame:** `tx` returns high the next cycle, the frame is abandoned, and nothing is transmitted afterwards.
- **Acceptance:**
  - `busy` rises the cycle after `cmd_valid`.
  - The start bit (`tx=0`) begins 2 cycles after `cmd_valid`: cycle 1 LOAD, cycle 2 SEND.
- **Serializer framing:**
  - start bit, 8 data bits LSB first, 1 stop bit; each bit is `BIT_CYCLES` cycles.
  - One byte takes `10*BIT_CYCLES` cycles.
- **Byte spacing:** the next start bit begins exactly 1 cycle after the previous stop bit ends (WAIT→SEND). Inter-byte idle is 1 clock.
- **Frame end:**
  - `frame_done` pulses the cycle after the final stop bit completes;
  - `busy` falls in the same cycle.
  - A command presented in that cycle is dropped. A command in the following cycle is accepted.
- **Simultaneous `result_valid` and `cmd_valid` in IDLE:** the LOAD snapshot takes the new result.
- **Frame lengths:**
  - digit frame = `6*(10*BIT_CYCLES+1)` cycles from first start bit to `frame_done`, ±1;
  - score frame = 45 bytes.

## Structure
- Shared package, `cnn_proto_pkg`:
  - markers `RESP_START1=8'hDD`, `RESP_START2=8'h77`, `RESP_END1=8'h77`, `RESP_END2=8'hDD`;
  - `CMD_DIGIT=8'hCC`, `CMD_SCORES=8'hCD`, `RESP_NACK=8'hEE`;
  - type codes `01` / `02`;
  - `NUM_CLASSES=10`, `SCORE_W=32`.
  - Receive-side markers move into the same package.
- One sub-module, `uart_tx`: bit-level serializer with ports `clk`, `rst`, `data[7:0]`, `start`, `tx`, `busy`, `done`. `done` is a one-cycle pulse at the end of the stop bit. It has its own baud counter and bit counter, and accepts `start` only when idle.
- Framer FSM, latches and byte mux live in `uart_result_tx`.

## Test plan
- **Digit frame:** `CLK_FREQ=16`, `BAUD=1`. `result_valid` with digit 7, then `cmd_valid` with `CC`. UART monitor decodes `DD 77 01 07 77 DD`; `frame_done` pulses exactly once; `busy` is low afterwards.
- **Score frame:** scores k = `32'h1000_0000+k`, score 9 = `32'hFFFF_FFF6`, then `CD`. Monitor decodes 45 bytes; byte 3 is `00`, byte 6 is `10`; the last payload bytes are `F6 FF FF FF`; the frame ends `77 DD`.
- **No result:** `CD` after reset with no `result_valid` → single byte `EE`, no markers, `frame_done` pulses.
- **Busy drop and mid-frame update:** during a `CD` frame, send `CC` and pulse `result_valid` with new data. The frame carries the old scores, no second frame follows, and a later `CC` reports the new digit.
- **Ignored byte, then reset:** `cmd_valid` with `0x41` → `tx` stays high, `busy` stays 0. Then start a `CD` frame, assert `rst` at byte 10 → `tx=1` the next cycle, `busy=0`, and a subsequent `CD` returns `EE`.
